// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings and tag layout for the hazard / forwarding unit.
// Tag bits from LSB: valid, regwrite, rd, memread, mul, rs[], rs_used[].
package hazard_fwd_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  localparam int OFS_VALID = 0;
  localparam int OFS_RW    = 1;
  localparam int OFS_RD    = 2;

  function automatic int ofs_mr(int aw);
    return 2 + aw;
  endfunction

  function automatic int ofs_mul(int aw);
    return 3 + aw;
  endfunction

  function automatic int ofs_rs(int aw);
    return 4 + aw;
  endfunction

  function automatic int ofs_used(int n, int aw);
    return 4 + aw + n * aw;
  endfunction

  function automatic int tag_w(int n, int aw);
    return 4 + aw + n * aw + n;
  endfunction

  // Downstream stages keep only the fields they still compare.
  function automatic int mem_w(int aw);
    return 3 + aw;
  endfunction

  function automatic int wb_w(int aw);
    return 2 + aw;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_hz_tag_stage.sv
// One destination-tag pipeline register with hold and bubble insert.
// Hold wins over bubble; bubble clears the whole tag.
module hz_tag_stage
  import hazard_fwd_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage core.
// Tracks EX/MEM/WB destination tags; stalls on load-use, branch and MUL.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 5,
  parameter int MUL_LAT      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           id_valid_i,
  input  logic [NUM_RD_PORTS*REG_AW-1:0] id_rs_i,
  input  logic [NUM_RD_PORTS-1:0]        id_rs_used_i,
  input  logic [REG_AW-1:0]              id_rd_i,
  input  logic                           id_regwrite_i,
  input  logic                           id_memread_i,
  input  logic                           id_mul_i,
  input  logic                           id_branch_i,
  input  logic                           flush_i,
  output logic                           stall_o,
  output logic [NUM_RD_PORTS*2-1:0]      fwd_ex_o,
  output logic [NUM_RD_PORTS*2-1:0]      fwd_id_o,
  output logic                           mul_busy_o
);

  localparam int N   = NUM_RD_PORTS;
  localparam int AW  = REG_AW;
  localparam int TW  = tag_w(N, AW);
  localparam int MW  = mem_w(AW);
  localparam int WW  = wb_w(AW);
  localparam int OMR = ofs_mr(AW);
  localparam int OML = ofs_mul(AW);
  localparam int ORS = ofs_rs(AW);
  localparam int OUS = ofs_used(N, AW);
  localparam int CW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  logic [TW-1:0]   id_tag;
  logic [TW-1:0]   ex_q;
  logic [MW-1:0]   mem_q;
  logic [WW-1:0]   wb_q;
  logic [CW-1:0]   cnt;
  logic            load_ex;
  logic [N-1:0]    lu_p;
  logic [N-1:0]    bh_p;

  logic            ex_v, ex_rw, ex_mr, ex_mul;
  logic [AW-1:0]   ex_rd;
  logic [N*AW-1:0] ex_rs;
  logic [N-1:0]    ex_used;
  logic            mem_v, mem_rw, mem_mr;
  logic [AW-1:0]   mem_rd;
  logic            wb_v, wb_rw;
  logic [AW-1:0]   wb_rd;

  assign id_tag = {id_rs_used_i, id_rs_i, id_mul_i,
                   id_memread_i, id_rd_i, id_regwrite_i, 1'b1};

  assign ex_v    = ex_q[OFS_VALID];
  assign ex_rw   = ex_q[OFS_RW];
  assign ex_rd   = ex_q[OFS_RD +: AW];
  assign ex_mr   = ex_q[OMR];
  assign ex_mul  = ex_q[OML];
  assign ex_rs   = ex_q[ORS +: N*AW];
  assign ex_used = ex_q[OUS +: N];

  assign mem_v  = mem_q[OFS_VALID];
  assign mem_rw = mem_q[OFS_RW];
  assign mem_rd = mem_q[OFS_RD +: AW];
  assign mem_mr = mem_q[OMR];

  assign wb_v  = wb_q[OFS_VALID];
  assign wb_rw = wb_q[OFS_RW];
  assign wb_rd = wb_q[OFS_RD +: AW];

  assign mul_busy_o = ex_v & ex_mul & (cnt != CNT_LAST);
  assign stall_o = id_valid_i
                 & ((|lu_p) | (|bh_p) | mul_busy_o);
  assign load_ex = id_valid_i & ~stall_o & ~flush_i;

  // Counter restarts whenever EX takes a new tag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (mul_busy_o) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  hz_tag_stage #(.W(TW)) u_ex (
    .clk    (clk_i),
    .rst    (rst_i),
    .hold   (mul_busy_o),
    .bubble (~load_ex),
    .d      (id_tag),
    .q      (ex_q)
  );

  hz_tag_stage #(.W(MW)) u_mem (
    .clk    (clk_i),
    .rst    (rst_i),
    .hold   (1'b0),
    .bubble (mul_busy_o),
    .d      (ex_q[MW-1:0]),
    .q      (mem_q)
  );

  hz_tag_stage #(.W(WW)) u_wb (
    .clk    (clk_i),
    .rst    (rst_i),
    .hold   (1'b0),
    .bubble (1'b0),
    .d      (mem_q[WW-1:0]),
    .q      (wb_q)
  );

  for (genvar p = 0; p < N; p++) begin : g_port
    logic [AW-1:0] id_rs_p;
    logic [AW-1:0] ex_rs_p;
    logic          m_ex, m_mem, m_wb;
    logic          e_mem, e_wb;

    assign id_rs_p = id_rs_i[p*AW +: AW];
    assign ex_rs_p = ex_rs[p*AW +: AW];

    assign m_ex  = ex_v & ex_rw & (ex_rd != '0)
                 & id_rs_used_i[p] & (ex_rd == id_rs_p);
    assign m_mem = mem_v & mem_rw & (mem_rd != '0)
                 & id_rs_used_i[p] & (mem_rd == id_rs_p);
    assign m_wb  = wb_v & wb_rw & (wb_rd != '0)
                 & id_rs_used_i[p] & (wb_rd == id_rs_p);

    assign e_mem = mem_v & mem_rw & (mem_rd != '0)
                 & ex_used[p] & (mem_rd == ex_rs_p);
    assign e_wb  = wb_v & wb_rw & (wb_rd != '0)
                 & ex_used[p] & (wb_rd == ex_rs_p);

    assign fwd_ex_o[2*p +: 2] =
      e_mem ? FWD_EXMEM : (e_wb ? FWD_MEMWB : FWD_RF);

    // A load still in MEM has no data yet; that case stalls instead.
    assign fwd_id_o[2*p +: 2] =
      (id_branch_i & m_mem & ~mem_mr) ? FWD_EXMEM :
      (id_branch_i & m_wb)            ? FWD_MEMWB : FWD_RF;

    assign lu_p[p] = ex_mr & m_ex;
    assign bh_p[p] = id_branch_i & (m_ex | (mem_mr & m_mem));
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit with a queue scoreboard.
// Driver pushes hand-computed expectations; a negedge monitor pops them.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_mul;
  logic       id_branch;
  logic       flush;
  logic       stall;
  logic [3:0] fwd_ex;
  logic [3:0] fwd_id;
  logic       mul_busy;

  typedef struct {
    int         id;
    logic       stall;
    logic [3:0] fex;
    logic [3:0] fid;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   vec_id = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rs_used_i  (id_rs_used),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .id_mul_i      (id_mul),
    .id_branch_i   (id_branch),
    .flush_i       (flush),
    .stall_o       (stall),
    .fwd_ex_o      (fwd_ex),
    .fwd_id_o      (fwd_id),
    .mul_busy_o    (mul_busy)
  );

  task automatic check(input string nm, input int id,
                       input logic [3:0] got,
                       input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %b want %b",
               nm, id, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m = sb.pop_front();
      check("stall", m.id, {3'b0, stall}, {3'b0, m.stall});
      check("fwd_ex", m.id, fwd_ex, m.fex);
      check("fwd_id", m.id, fwd_id, m.fid);
      check("mul_busy", m.id, {3'b0, mul_busy}, {3'b0, m.busy});
    end
  end

  task automatic idle_in();
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rs_used  = '0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
    id_mul      = 1'b0;
    id_branch   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic cyc(input logic v,
                     input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic [1:0] used, input logic [4:0] rd,
                     input logic rw, input logic mr,
                     input logic mu, input logic br,
                     input logic fl,
                     input logic e_stall, input logic [3:0] e_fex,
                     input logic [3:0] e_fid, input logic e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_mul      = mu;
    id_branch   = br;
    flush       = fl;
    vec_id++;
    e.id    = vec_id;
    e.stall = e_stall;
    e.fex   = e_fex;
    e.fid   = e_fid;
    e.busy  = e_busy;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [3:0] e_fex);
    cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, e_fex, 4'h0, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();

    // reset state, including a load presented during reset
    idle(4'h0);
    cyc(1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    @(negedge clk);
    #1;
    idle_in();
    rst = 1'b0;
    idle(4'h0);

    // add r3; add r3,r1,r1; add r4,r3,r3; add r15,r4,r3
    cyc(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 1, 1, 2'b11, 3, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 4, 3, 2'b11, 15, 1, 0, 0, 0, 0, 0, 4'b0101, 4'h0, 0);
    idle(4'b1001);
    idle(4'h0);
    idle(4'h0);

    // lw r5; sub r6,r5,r1
    cyc(1, 1, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0);
    cyc(1, 5, 1, 2'b11, 6, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    idle(4'b0010);
    idle(4'h0);
    idle(4'h0);

    // add r7; beq r7,r0
    cyc(1, 1, 2, 2'b11, 7, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 7, 0, 2'b11, 0, 0, 0, 0, 1, 0, 1, 4'h0, 4'h0, 0);
    cyc(1, 7, 0, 2'b11, 0, 0, 0, 0, 1, 0, 0, 4'h0, 4'b0001, 0);
    idle(4'b0010);
    idle(4'h0);
    idle(4'h0);

    // lw r7; beq r7,r0
    cyc(1, 1, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 7, 0, 2'b11, 0, 0, 0, 0, 1, 0, 1, 4'h0, 4'h0, 0);
    cyc(1, 7, 0, 2'b11, 0, 0, 0, 0, 1, 0, 1, 4'h0, 4'h0, 0);
    cyc(1, 7, 0, 2'b11, 0, 0, 0, 0, 1, 0, 0, 4'h0, 4'b0010, 0);
    idle(4'h0);
    idle(4'h0);
    idle(4'h0);

    // mul r8; add r9,r8,r1
    cyc(1, 1, 2, 2'b11, 8, 1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 0);
    repeat (3)
      cyc(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1);
    cyc(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    idle(4'b0001);
    idle(4'h0);
    idle(4'h0);

    // r0 destinations and unused source ports
    cyc(1, 1, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 0, 0, 2'b11, 6, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 1, 0, 2'b01, 10, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 10, 10, 2'b00, 11, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    idle(4'h0);
    idle(4'h0);
    idle(4'h0);

    // flush with and without a load-use hazard
    cyc(1, 1, 0, 2'b01, 12, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 12, 1, 2'b11, 13, 1, 0, 0, 0, 1, 1, 4'h0, 4'h0, 0);
    cyc(1, 12, 12, 2'b11, 13, 1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 0);
    idle(4'h0);
    idle(4'h0);
    idle(4'h0);

    // async reset on the second MUL hold cycle
    cyc(1, 1, 2, 2'b11, 8, 1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 0);
    cyc(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1);
    cyc(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    vec_id++;
    check("rst_stall", vec_id, {3'b0, stall}, 4'h0);
    check("rst_fwd_ex", vec_id, fwd_ex, 4'h0);
    check("rst_fwd_id", vec_id, fwd_id, 4'h0);
    check("rst_mul_busy", vec_id, {3'b0, mul_busy}, 4'h0);
    cyc(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    @(negedge clk);
    #1;
    idle_in();
    rst = 1'b0;
    idle(4'h0);
    cyc(1, 1, 2, 2'b11, 8, 1, 0, 1, 0, 0, 0, 4'h0, 4'h0, 0);
    repeat (3)
      cyc(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1);
    cyc(1, 8, 1, 2'b11, 9, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    idle(4'b0001);
    idle(4'h0);
    idle(4'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
